// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared types and helpers for the UART transmit arbiter.
//    arb_state_t : arbiter FSM states
//    HDR_MARKER  : tag byte base, present only with UART_TX_ARB_ID_HDR_EN
//    grant_w()   : index width for n items, clog2(n) with a floor of 1
package uart_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
`ifdef UART_TX_ARB_ID_HDR_EN
      HDR    = 2'd1,
`endif
      STREAM = 2'd2
   } arb_state_t;

`ifdef UART_TX_ARB_ID_HDR_EN
   localparam logic [7:0] HDR_MARKER = 8'hF0;
`endif

   function automatic int grant_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority select.
// Ports:
//    i_req     : request vector, one bit per requester
//    i_ptr     : search start index (highest priority this round)
//    o_any_req : at least one request is set
//    o_pick    : first set request at or after i_ptr, wrapping
module rr_pick
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]           i_req,
   input  logic [grant_w(NUM_REQ)-1:0]  i_ptr,
   output logic                         o_any_req,
   output logic [grant_w(NUM_REQ)-1:0]  o_pick
);

   localparam int GW = grant_w(NUM_REQ);

   // Walk offsets from farthest to nearest so the nearest set request wins.
   always_comb begin
      o_any_req = |i_req;
      o_pick    = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (i_req[(int'(i_ptr) + k) % NUM_REQ]) begin
            o_pick = GW'((int'(i_ptr) + k) % NUM_REQ);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-level round-robin arbiter sharing one UART transmit
// channel among NUM_REQ byte-stream requesters. A grant is held from the first
// byte to req_last; a watchdog revokes a grant whose requester stalls
// mid-packet for TIMEOUT cycles.
// Optional build macro UART_TX_ARB_ID_HDR_EN: prefix every packet with one
// tag byte 0xF0 | grant_id.
// Ports:
//    clk, rst_n     : clock; asynchronous reset, asserted high
//    i_req_valid    : per-requester byte valid
//    i_req_data     : per-requester byte, requester i at [i*DATA_BIT +: DATA_BIT]
//    i_req_last     : final byte of packet, qualified by i_req_valid
//    o_req_ready    : per-requester accept
//    o_tx_valid     : to UART tx_valid
//    o_tx_data      : to UART tx_data
//    i_tx_ready     : from UART tx_ready
//    o_grant_id     : current or last granted requester
//    o_busy         : grant held (state other than IDLE)
//    o_timeout_err  : one-cycle pulse on watchdog revoke
//
// state  | meaning
// IDLE   | no grant; arbitrate, one bubble cycle, no transfers
// HDR    | send tag byte for the new grant (UART_TX_ARB_ID_HDR_EN only)
// STREAM | pass granted requester through until req_last or watchdog
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int DATA_BIT = 8,
   parameter int TIMEOUT  = 100000
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            i_req_valid,
   input  logic [NUM_REQ*DATA_BIT-1:0]   i_req_data,
   input  logic [NUM_REQ-1:0]            i_req_last,
   output logic [NUM_REQ-1:0]            o_req_ready,
   output logic                          o_tx_valid,
   output logic [DATA_BIT-1:0]           o_tx_data,
   input  logic                          i_tx_ready,
   output logic [grant_w(NUM_REQ)-1:0]   o_grant_id,
   output logic                          o_busy,
   output logic                          o_timeout_err
);

   localparam int GW = grant_w(NUM_REQ);
   // Counter only ever needs to reach TIMEOUT-1.
   localparam int CW = grant_w(TIMEOUT);

   arb_state_t        r_state;
   arb_state_t        w_state_nxt;
   logic [GW-1:0]     r_rr_ptr;
   logic [GW-1:0]     r_grant_id;
   logic [CW-1:0]     r_wd_cnt;
   logic              r_timeout_err;

   logic              w_any_req;
   logic [GW-1:0]     w_pick;
   logic              w_g_valid;
   logic              w_g_last;
   logic [DATA_BIT-1:0] w_g_data;
   logic [GW-1:0]     w_next_ptr;
   logic              w_pkt_done;
   logic              w_wd_fire;

   rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_pick (
      .i_req     (i_req_valid),
      .i_ptr     (r_rr_ptr),
      .o_any_req (w_any_req),
      .o_pick    (w_pick)
   );

   assign w_g_valid  = i_req_valid[r_grant_id];
   assign w_g_last   = i_req_last[r_grant_id];
   assign w_g_data   = i_req_data[int'(r_grant_id)*DATA_BIT +: DATA_BIT];
   // Explicit wrap so non-power-of-two NUM_REQ is handled.
   assign w_next_ptr = (r_grant_id == GW'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      o_tx_valid  = 1'b0;
      o_tx_data   = '0;
      o_req_ready = '0;
      w_pkt_done  = 1'b0;
      w_wd_fire   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_any_req) begin
`ifdef UART_TX_ARB_ID_HDR_EN
               w_state_nxt = HDR;
`else
               w_state_nxt = STREAM;
`endif
            end
         end
`ifdef UART_TX_ARB_ID_HDR_EN
         HDR: begin
            o_tx_valid = 1'b1;
            o_tx_data  = DATA_BIT'(HDR_MARKER) | DATA_BIT'(r_grant_id);
            if (i_tx_ready) begin
               w_state_nxt = STREAM;
            end
         end
`endif
         STREAM: begin
            o_tx_valid              = w_g_valid;
            o_tx_data               = w_g_data;
            o_req_ready[r_grant_id] = i_tx_ready;
            if (w_g_valid && i_tx_ready && w_g_last) begin
               w_pkt_done  = 1'b1;
               w_state_nxt = IDLE;
            end else if (!w_g_valid && (r_wd_cnt == CW'(TIMEOUT - 1))) begin
               w_wd_fire   = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         r_rr_ptr      <= '0;
         r_grant_id    <= '0;
         r_wd_cnt      <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         r_timeout_err <= w_wd_fire;
         if ((r_state == IDLE) && w_any_req) begin
            r_grant_id <= w_pick;
         end
         if (w_pkt_done || w_wd_fire) begin
            r_rr_ptr <= w_next_ptr;
         end
         // Only idle STREAM cycles with no state change accumulate; a
         // tx_ready stall keeps req_valid high and so never counts.
         if ((r_state != STREAM) || (w_state_nxt != STREAM) || w_g_valid) begin
            r_wd_cnt <= '0;
         end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
         end
      end
   end

   assign o_grant_id    = r_grant_id;
   assign o_busy        = (r_state != IDLE);
   assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int TO = 20;

   typedef struct {
      logic [7:0] data;
      int         owner;
      bit         hdr;
      bit         last;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    i_req_valid = '0;
   logic [N*DW-1:0] i_req_data = '0;
   logic [N-1:0]    i_req_last = '0;
   logic [N-1:0]    o_req_ready;
   logic            o_tx_valid;
   logic [DW-1:0]   o_tx_data;
   logic            i_tx_ready = 1'b0;
   logic [1:0]      o_grant_id;
   logic            o_busy;
   logic            o_timeout_err;

   int n_tests = 0;
   int n_fail  = 0;

   logic [8:0] aq [N][$];
   logic [8:0] mq [N][$];
   int         gap [N];
   exp_t       exp_q [$];
   int         m_ptr = 0;

   uart_tx_arbiter #(.NUM_REQ(N), .DATA_BIT(DW), .TIMEOUT(TO)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_req_valid   (i_req_valid),
      .i_req_data    (i_req_data),
      .i_req_last    (i_req_last),
      .o_req_ready   (o_req_ready),
      .o_tx_valid    (o_tx_valid),
      .o_tx_data     (o_tx_data),
      .i_tx_ready    (i_tx_ready),
      .o_grant_id    (o_grant_id),
      .o_busy        (o_busy),
      .o_timeout_err (o_timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic add_byte(input int r, input logic [7:0] d, input bit last);
      aq[r].push_back({last, d});
      mq[r].push_back({last, d});
   endtask

   // Reference: whole packets granted round robin among requesters that still
   // have packets, starting at m_ptr.
   task automatic model_build();
      int j;
      exp_t e;
      logic [8:0] b;
      while (1) begin
         j = -1;
         for (int k = 0; k < N; k++)
            if (j < 0 && mq[(m_ptr + k) % N].size() > 0) j = (m_ptr + k) % N;
         if (j < 0) break;
`ifdef UART_TX_ARB_ID_HDR_EN
         e.data = 8'hF0 | 8'(j); e.owner = j; e.hdr = 1; e.last = 0;
         exp_q.push_back(e);
`endif
         do begin
            b = mq[j].pop_front();
            e.data = b[7:0]; e.owner = j; e.hdr = 0; e.last = b[8];
            exp_q.push_back(e);
         end while (!e.last && mq[j].size() > 0);
         m_ptr = (j + 1) % N;
      end
   endtask

   task automatic drive_inputs();
      for (int i = 0; i < N; i++) begin
         if (aq[i].size() > 0 && gap[i] == 0) begin
            i_req_valid[i]         = 1'b1;
            i_req_data[i*DW +: DW] = aq[i][0][7:0];
            i_req_last[i]          = aq[i][0][8];
         end else begin
            i_req_valid[i]         = 1'b0;
            i_req_data[i*DW +: DW] = '0;
            i_req_last[i]          = 1'b0;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b1;
      i_req_valid = '0; i_req_data = '0; i_req_last = '0; i_tx_ready = 1'b0;
      for (int i = 0; i < N; i++) begin
         aq[i].delete(); mq[i].delete(); gap[i] = 0;
      end
      exp_q.delete();
      m_ptr = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
   endtask

   task automatic run_traffic(input string tag, input int max_cyc, input int exp_to);
      exp_t e;
      logic [N-1:0] er;
      bit l;
      bit prev_last = 0;
      int cyc = 0;
      int to_cnt = 0;
      while ((exp_q.size() > 0 || prev_last) && cyc < max_cyc) begin
         @(negedge clk);
         for (int i = 0; i < N; i++) if (gap[i] > 0) gap[i]--;
         i_tx_ready = ($urandom_range(0, 3) != 0);
         drive_inputs();
         #1;
         if (o_timeout_err) to_cnt++;
         if (prev_last)
            chk({tag, " bubble"}, int'({o_busy, o_tx_valid, |o_req_ready}), 0);
         prev_last = 0;
         if (o_tx_valid && i_tx_ready) begin
            if (exp_q.size() == 0) begin
               chk({tag, " extra byte"}, int'(o_tx_data), -1);
            end else begin
               e = exp_q.pop_front();
               er = '0;
               if (!e.hdr) er[e.owner] = 1'b1;
               chk({tag, " data"}, int'(o_tx_data), int'(e.data));
               chk({tag, " grant"}, int'(o_grant_id), e.owner);
               chk({tag, " ready"}, int'(o_req_ready), int'(er));
               if (e.last) prev_last = 1;
            end
            for (int i = 0; i < N; i++) begin
               if (i_req_valid[i] && o_req_ready[i] && aq[i].size() > 0) begin
                  l = aq[i][0][8];
                  void'(aq[i].pop_front());
                  gap[i] = l ? 0 : int'($urandom_range(0, 4));
               end
            end
         end
         cyc++;
      end
      chk({tag, " drained"}, exp_q.size(), 0);
      chk({tag, " timeouts"}, to_cnt, exp_to);
   endtask

   initial begin
      int n;
      bit got;
      bit saw_tx;

      // reset state
      #2 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("rst tx_valid", int'(o_tx_valid), 0);
      chk("rst tx_data", int'(o_tx_data), 0);
      chk("rst req_ready", int'(o_req_ready), 0);
      chk("rst busy", int'(o_busy), 0);
      chk("rst timeout_err", int'(o_timeout_err), 0);
      chk("rst grant_id", int'(o_grant_id), 0);
      rst_n = 1'b0;

      // single packet
      add_byte(1, 8'hA5, 0); add_byte(1, 8'h5A, 0); add_byte(1, 8'hFF, 1);
      model_build();
      run_traffic("single", 500, 0);
      chk("single gid", int'(o_grant_id), 1);

      // contention from rr_ptr 0, then confirm pointer landed on 3
      do_reset();
      add_byte(0, 8'h11, 0); add_byte(0, 8'h12, 1);
      add_byte(2, 8'h21, 0); add_byte(2, 8'h22, 1);
      model_build();
      run_traffic("contend", 500, 0);
      add_byte(0, 8'h01, 1); add_byte(3, 8'h03, 1);
      model_build();
      run_traffic("contend ptr", 500, 0);

      // fairness
      do_reset();
      for (int p = 0; p < 2; p++)
         for (int i = 0; i < N; i++) add_byte(i, 8'(i), 1);
      model_build();
      run_traffic("fair", 500, 0);

      // randomized packets
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < N; i++) begin
            int np = $urandom_range(0, 2);
            for (int p = 0; p < np; p++) begin
               int len = $urandom_range(1, 4);
               for (int k = 0; k < len; k++) add_byte(i, 8'($urandom), k == len - 1);
            end
         end
         model_build();
         run_traffic("rand", 2000, 0);
      end

      // watchdog: leave rr_ptr at 2, then stall requester 3 mid-packet
      do_reset();
      add_byte(1, 8'h42, 1);
      model_build();
      run_traffic("wd pre", 500, 0);
      @(negedge clk);
      i_req_valid = '0; i_req_last = '0; i_req_data = '0;
      i_req_valid[3] = 1'b1; i_req_data[3*DW +: DW] = 8'h3A; i_tx_ready = 1'b1;
      got = 0;
      for (int c = 0; c < 10 && !got; c++) begin
         @(negedge clk); #1;
         if (o_tx_valid && i_tx_ready && o_req_ready[3]) got = 1;
      end
      chk("wd first byte", int'(got), 1);
      chk("wd gid", int'(o_grant_id), 3);
      @(negedge clk);
      add_byte(0, 8'h77, 1); add_byte(2, 8'h99, 1);
      m_ptr = (3 + 1) % N;
      model_build();
      drive_inputs();
      n = 0; got = 0; saw_tx = 0;
      while (!got && n < 40) begin
         @(posedge clk); n++; #1;
         if (o_tx_valid) saw_tx = 1;
         if (o_timeout_err) got = 1;
      end
      chk("wd delay", n, TO);
      chk("wd no fill", int'(saw_tx), 0);
      run_traffic("wd post", 500, 1);

      // async reset mid-packet
      do_reset();
      @(negedge clk);
      i_req_valid[1] = 1'b1; i_req_data[1*DW +: DW] = 8'h10; i_tx_ready = 1'b0;
      got = 0;
      for (int c = 0; c < 10 && !got; c++) begin
         @(negedge clk); #1;
         if (o_tx_valid) got = 1;
      end
      chk("arst tx_valid before", int'(got), 1);
      rst_n = 1'b1;
      #1;
      chk("arst outputs", int'({o_tx_valid, o_busy, o_req_ready, o_tx_data, o_timeout_err}), 0);
      chk("arst grant_id", int'(o_grant_id), 0);
      @(negedge clk);
      i_req_valid = '0; i_req_data = '0;
      rst_n = 1'b0;
      add_byte(2, 8'h55, 1); add_byte(1, 8'h66, 1);
      model_build();
      run_traffic("arst regrant", 500, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
